// File: rtl/fractal_sync_tx_mc.sv
// Multi-channel sync response transmit datapath: samples a response and broadcasts it into masked per-channel FIFOs.
// Optional FRACTAL_SYNC_TX_MC_DROP_CNT_EN adds per-channel 8-bit saturating dropped-push counters.
package fractal_sync_tx_mc_pkg;
    typedef struct packed {
        logic [2:0] tag;
        logic       wake;
        logic       grant;
    } fsync_rsp_t;
endpackage

module fractal_sync_tx_mc #(
    parameter type         fsync_rsp_t   = fractal_sync_tx_mc_pkg::fsync_rsp_t,
    parameter int unsigned N_CHANNELS    = 2,
    parameter bit          COMB_IN       = 1'b0,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter bit          FIFO_COMB_OUT = 1'b1,
    parameter int unsigned LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  fsync_rsp_t                                rsp_i,
    output fsync_rsp_t                                sampled_rsp_o,
    output logic                                      check_propagate_o,
    output logic                                      check_lock_o,
    input  logic [N_CHANNELS-1:0]                     propagate_i,
    input  logic                                      err_clr_i,
    output logic [N_CHANNELS-1:0]                     overflow_o,
    output logic [N_CHANNELS-1:0]                     underflow_o,
    output logic [N_CHANNELS-1:0]                     empty_o,
    output logic [N_CHANNELS*LVL_W-1:0]               level_o,
    output logic [N_CHANNELS*$bits(fsync_rsp_t)-1:0]  rsp_o,
    input  logic [N_CHANNELS-1:0]                     pop_i
`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
   ,output logic [N_CHANNELS*8-1:0]                   drop_cnt_o
`endif
);

    localparam int unsigned RSP_W = $bits(fsync_rsp_t);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (N_CHANNELS < 1) begin : g_bad_channels
        $fatal(1, "fractal_sync_tx_mc: N_CHANNELS must be >= 1");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $fatal(1, "fractal_sync_tx_mc: FIFO_DEPTH must be >= 1");
    end

    logic       s_wake;
    logic       s_grant;
    fsync_rsp_t s_rsp;
    logic       s_valid;

    generate
        if (COMB_IN) begin : g_comb_in
            assign s_wake  = rsp_i.wake;
            assign s_grant = rsp_i.grant;
            assign s_rsp   = rsp_i;
        end else begin : g_reg_in
            logic       wake_reg;
            logic       grant_reg;
            fsync_rsp_t rsp_reg;

            // Flags follow the input every cycle; the payload only latches on a valid response.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wake_reg  <= 1'b0;
                    grant_reg <= 1'b0;
                    rsp_reg   <= '0;
                end else begin
                    wake_reg  <= rsp_i.wake;
                    grant_reg <= rsp_i.grant;
                    if (rsp_i.wake || rsp_i.grant) begin
                        rsp_reg <= rsp_i;
                    end
                end
            end

            assign s_wake  = wake_reg;
            assign s_grant = grant_reg;
            assign s_rsp   = rsp_reg;
        end
    endgenerate

    assign s_valid           = s_wake | s_grant;
    assign sampled_rsp_o     = s_rsp;
    assign check_propagate_o = s_wake;
    assign check_lock_o      = s_grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
            logic             push, pop, full, empty, fall, wr_en, rd_en, drop, under;
            logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [LVL_W-1:0] cnt_reg;
            logic             ovf_reg, udf_reg;
            fsync_rsp_t       mem [FIFO_DEPTH];
            fsync_rsp_t       head, hold_reg;

            assign push  = s_valid & propagate_i[gi];
            assign pop   = pop_i[gi];
            assign empty = (cnt_reg == '0);
            assign full  = (cnt_reg == LVL_W'(FIFO_DEPTH));
            // Push and pop on an empty fall-through channel hand the element straight out.
            assign fall  = FIFO_COMB_OUT && empty && push && pop;
            assign rd_en = pop && !empty;
            assign wr_en = push && !fall && (!full || pop);
            assign drop  = push && full && !pop;
            assign under = pop && empty && !fall;

            always_ff @(posedge clk_i) begin
                if (wr_en) begin
                    mem[wr_ptr_reg] <= s_rsp;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                    ovf_reg    <= 1'b0;
                    udf_reg    <= 1'b0;
                    hold_reg   <= '0;
                end else begin
                    if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    if (rd_en) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    if (wr_en && !rd_en) cnt_reg <= cnt_reg + LVL_W'(1);
                    else if (rd_en && !wr_en) cnt_reg <= cnt_reg - LVL_W'(1);
                    ovf_reg  <= drop  | (ovf_reg & ~err_clr_i);
                    udf_reg  <= under | (udf_reg & ~err_clr_i);
                    hold_reg <= head;
                end
            end

            always_comb begin
                head = hold_reg;
                if (!empty) begin
                    head = mem[rd_ptr_reg];
                end else if (FIFO_COMB_OUT && push) begin
                    head = s_rsp;
                end
            end

            assign overflow_o[gi]                 = ovf_reg;
            assign underflow_o[gi]                = udf_reg;
            assign empty_o[gi]                    = empty;
            assign level_o[gi*LVL_W +: LVL_W]     = cnt_reg;
            assign rsp_o[gi*RSP_W +: RSP_W]       = head;

`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
            logic [7:0] drop_cnt_reg;

            // A drop coinciding with a clear counts as the first drop after the clear.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    drop_cnt_reg <= '0;
                end else if (err_clr_i) begin
                    drop_cnt_reg <= {7'd0, drop};
                end else if (drop && drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
            end

            assign drop_cnt_o[gi*8 +: 8] = drop_cnt_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_fractal_sync_tx_mc.sv
// Randomized self-checking bench for fractal_sync_tx_mc against a queue-based reference model.
module tb_fractal_sync_tx_mc;
    import fractal_sync_tx_mc_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 2;
    localparam bit CIN   = 1'b0;
    localparam bit COUT  = 1'b1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int RW    = $bits(fsync_rsp_t);

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    fsync_rsp_t            rsp_i = '0;
    fsync_rsp_t            sampled_rsp_o;
    logic                  check_propagate_o, check_lock_o;
    logic [N-1:0]          propagate_i = '0;
    logic                  err_clr_i = 1'b0;
    logic [N-1:0]          overflow_o, underflow_o, empty_o;
    logic [N*LVL_W-1:0]    level_o;
    logic [N*RW-1:0]       rsp_o;
    logic [N-1:0]          pop_i = '0;
`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
    logic [N*8-1:0]        drop_cnt_o;
`endif

    fractal_sync_tx_mc #(
        .fsync_rsp_t   (fsync_rsp_t),
        .N_CHANNELS    (N),
        .COMB_IN       (CIN),
        .FIFO_DEPTH    (DEPTH),
        .FIFO_COMB_OUT (COUT)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .rsp_i             (rsp_i),
        .sampled_rsp_o     (sampled_rsp_o),
        .check_propagate_o (check_propagate_o),
        .check_lock_o      (check_lock_o),
        .propagate_i       (propagate_i),
        .err_clr_i         (err_clr_i),
        .overflow_o        (overflow_o),
        .underflow_o       (underflow_o),
        .empty_o           (empty_o),
        .level_o           (level_o),
        .rsp_o             (rsp_o),
        .pop_i             (pop_i)
`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
       ,.drop_cnt_o        (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per channel plus the sampled response and sticky flags.
    fsync_rsp_t m_q [N][$];
    logic       m_ovf [N];
    logic       m_udf [N];
    int         m_drop [N];
    logic       m_wake, m_grant;
    fsync_rsp_t m_rsp;

    function automatic fsync_rsp_t mk(input int tag, input bit wake, input bit grant);
        fsync_rsp_t r;
        r.tag   = 3'(tag);
        r.wake  = wake;
        r.grant = grant;
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_q[c].delete();
            m_ovf[c]  = 1'b0;
            m_udf[c]  = 1'b0;
            m_drop[c] = 0;
        end
        m_wake  = 1'b0;
        m_grant = 1'b0;
        m_rsp   = '0;
    endtask

    task automatic check_outputs(input string ph);
        logic       w, g;
        fsync_rsp_t sr;
        w  = CIN ? rsp_i.wake  : m_wake;
        g  = CIN ? rsp_i.grant : m_grant;
        sr = CIN ? rsp_i : m_rsp;
        check({ph, ".check_propagate"}, 64'(check_propagate_o), 64'(w));
        check({ph, ".check_lock"},      64'(check_lock_o),      64'(g));
        check({ph, ".sampled_rsp"},     64'(sampled_rsp_o),     64'(sr));
        for (int c = 0; c < N; c++) begin
            logic push;
            push = (w | g) & propagate_i[c];
            check($sformatf("%s.empty%0d", ph, c),     64'(empty_o[c]), 64'(m_q[c].size() == 0));
            check($sformatf("%s.level%0d", ph, c),     64'(level_o[c*LVL_W +: LVL_W]), 64'(m_q[c].size()));
            check($sformatf("%s.overflow%0d", ph, c),  64'(overflow_o[c]), 64'(m_ovf[c]));
            check($sformatf("%s.underflow%0d", ph, c), 64'(underflow_o[c]), 64'(m_udf[c]));
            if (m_q[c].size() != 0)
                check($sformatf("%s.rsp%0d", ph, c), 64'(rsp_o[c*RW +: RW]), 64'(m_q[c][0]));
            else if (COUT && push)
                check($sformatf("%s.fallthru%0d", ph, c), 64'(rsp_o[c*RW +: RW]), 64'(sr));
`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
            check($sformatf("%s.drop_cnt%0d", ph, c), 64'(drop_cnt_o[c*8 +: 8]), 64'(m_drop[c]));
`endif
        end
    endtask

    task automatic model_update();
        logic       w, g, push, pop, drop, under;
        fsync_rsp_t sr;
        w  = CIN ? rsp_i.wake  : m_wake;
        g  = CIN ? rsp_i.grant : m_grant;
        sr = CIN ? rsp_i : m_rsp;
        for (int c = 0; c < N; c++) begin
            push  = (w | g) & propagate_i[c];
            pop   = pop_i[c];
            drop  = 1'b0;
            under = 1'b0;
            if (m_q[c].size() == 0) begin
                if (pop && push && COUT) begin
                    // element passes straight through; nothing stored
                end else begin
                    if (pop) under = 1'b1;
                    if (push) m_q[c].push_back(sr);
                end
            end else begin
                if (push && m_q[c].size() == DEPTH && !pop) drop = 1'b1;
                if (pop) void'(m_q[c].pop_front());
                if (push && !drop) m_q[c].push_back(sr);
            end
            m_ovf[c] = drop  | (m_ovf[c] & ~err_clr_i);
            m_udf[c] = under | (m_udf[c] & ~err_clr_i);
            if (err_clr_i) m_drop[c] = drop ? 1 : 0;
            else if (drop && m_drop[c] < 255) m_drop[c]++;
        end
        if (!CIN) begin
            m_wake  = rsp_i.wake;
            m_grant = rsp_i.grant;
            if (rsp_i.wake || rsp_i.grant) m_rsp = rsp_i;
        end
    endtask

    task automatic step(input string ph, input fsync_rsp_t r, input logic [N-1:0] prop,
                        input logic [N-1:0] pop, input logic clr);
        @(negedge clk);
        rsp_i       = r;
        propagate_i = prop;
        pop_i       = pop;
        err_clr_i   = clr;
        #1;
        check_outputs(ph);
        $display("txn %-10s rsp=%02h prop=%b pop=%b clr=%b lvl=%h empty=%b ovf=%b udf=%b",
                 ph, r, prop, pop, clr, level_o, empty_o, overflow_o, underflow_o);
        model_update();
    endtask

    task automatic do_reset(input string ph);
        @(negedge clk);
        rsp_i       = '0;
        propagate_i = '0;
        pop_i       = '0;
        err_clr_i   = 1'b0;
        rst_ni      = 1'b0;
        #1;
        model_reset();
        check_outputs(ph);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset");
        do_reset("reset2");

        // Basic: wake then route to ch0
        step("basic", mk(1, 1, 0), 2'b00, 2'b00, 1'b0);
        step("basic", mk(0, 0, 0), 2'b01, 2'b00, 1'b0);
        step("basic", mk(0, 0, 0), 2'b00, 2'b00, 1'b0);
        step("basic", mk(0, 0, 0), 2'b00, 2'b01, 1'b0);

        // Broadcast grant, pop ch1 only, then drain
        step("bcast", mk(2, 0, 1), 2'b00, 2'b00, 1'b0);
        step("bcast", mk(0, 0, 0), 2'b11, 2'b00, 1'b0);
        step("bcast", mk(0, 0, 0), 2'b00, 2'b10, 1'b0);
        step("bcast", mk(0, 0, 0), 2'b00, 2'b01, 1'b0);

        // Overflow isolation and clear
        step("ovf", mk(3, 1, 0), 2'b00, 2'b00, 1'b0);
        step("ovf", mk(4, 1, 0), 2'b01, 2'b00, 1'b0);
        step("ovf", mk(5, 0, 1), 2'b01, 2'b00, 1'b0);
        step("ovf", mk(0, 0, 0), 2'b11, 2'b00, 1'b0);
        step("ovf", mk(0, 0, 0), 2'b00, 2'b00, 1'b0);
        step("ovf", mk(0, 0, 0), 2'b00, 2'b00, 1'b1);
        step("ovf", mk(0, 0, 0), 2'b00, 2'b00, 1'b0);

        // Full channel push+pop, then drain to confirm order
        step("fullpp", mk(6, 1, 1), 2'b00, 2'b10, 1'b0);
        step("fullpp", mk(0, 0, 0), 2'b01, 2'b01, 1'b0);
        step("fullpp", mk(0, 0, 0), 2'b00, 2'b01, 1'b0);
        step("fullpp", mk(0, 0, 0), 2'b00, 2'b01, 1'b0);

        // Underflow on ch1, fall-through on ch0
        step("udf", mk(7, 1, 0), 2'b00, 2'b10, 1'b0);
        step("udf", mk(0, 0, 0), 2'b01, 2'b01, 1'b0);
        step("udf", mk(0, 0, 0), 2'b00, 2'b00, 1'b0);

        // Reset mid-operation with both channels full
        step("mid", mk(1, 1, 0), 2'b00, 2'b00, 1'b1);
        step("mid", mk(2, 0, 1), 2'b11, 2'b00, 1'b0);
        step("mid", mk(0, 0, 0), 2'b11, 2'b00, 1'b0);
        step("mid", mk(0, 0, 0), 2'b00, 2'b00, 1'b0);
        do_reset("midrst");

`ifdef FRACTAL_SYNC_TX_MC_DROP_CNT_EN
        // Saturating drop counter: 300 drops on a full ch0
        for (int i = 0; i < 303; i++)
            step("dropcnt", mk(i, 1, 0), 2'b01, 2'b00, 1'b0);
        step("dropcnt", mk(0, 0, 0), 2'b00, 2'b00, 1'b0);
        do_reset("droprst");
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            fsync_rsp_t r;
            logic [N-1:0] pm, pp;
            r       = fsync_rsp_t'($urandom);
            r.wake  = ($urandom_range(0, 2) == 0);
            r.grant = ($urandom_range(0, 2) == 0);
            pm      = N'($urandom);
            for (int c = 0; c < N; c++) pp[c] = ($urandom_range(0, 9) < 3);
            if (i == 750) do_reset("rndrst");
            step("rand", r, pm, pp, ($urandom_range(0, 99) < 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fractal_sync_tx_mc.md
Name: fractal_sync_tx_mc

Overview:
Multi-channel synchronization response transmit datapath for the fractal sync tree.
- Samples an incoming response (wake/grant) and exposes it to the routing logic.
- Broadcasts the response into any subset of N_CHANNELS per-channel FIFOs, selected by a propagate mask.
- Keeps sticky per-channel overflow/underflow status with software clear, plus occupancy reporting.
- Sits between a tree node's response arbiter and its downstream channel links (e.g. the EN/WS links in a 2-channel configuration).

Parameters:
fsync_rsp_t, logic, response type; must contain 1-bit fields wake and grant.
N_CHANNELS, 2, number of output channels; must be >= 1.
COMB_IN, 0, 1: combinational input path; 0: input registered.
FIFO_DEPTH, 2, entries per channel FIFO; must be >= 1.
FIFO_COMB_OUT, 1, 1: fall-through FIFO output; 0: registered output.
LVL_W, $clog2(FIFO_DEPTH+1), width of the occupancy outputs (derived).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rsp_i  in  $bits(fsync_rsp_t)  incoming response
sampled_rsp_o  out  $bits(fsync_rsp_t)  sampled response, presented to the routing logic
check_propagate_o  out  1  sampled wake valid; routing must return propagate_i
check_lock_o  out  1  sampled grant valid; routing must return propagate_i
propagate_i  in  N_CHANNELS  per-channel push mask for the current sampled response
err_clr_i  in  1  clears all sticky error bits
overflow_o  out  N_CHANNELS  sticky: a push was dropped on a full channel
underflow_o  out  N_CHANNELS  sticky: a pop was issued to an empty channel
empty_o  out  N_CHANNELS  per-channel FIFO empty
level_o  out  N_CHANNELS*LVL_W  per-channel occupancy, channel c at [c*LVL_W +: LVL_W]
rsp_o  out  N_CHANNELS*$bits(fsync_rsp_t)  per-channel head element
pop_i  in  N_CHANNELS  per-channel pop

Behaviour:
- Reset: all outputs 0. Exception: empty_o = all ones. FIFOs flushed, sticky errors cleared. Reset asserted mid-operation discards all stored responses immediately.
- Sampling, COMB_IN=0:
  - sampled wake/grant register rsp_i.wake/.grant every cycle.
  - sampled_rsp_o loads rsp_i only when (wake|grant); otherwise it holds its value.
- Sampling, COMB_IN=1: all sampled values are rsp_i directly.
- Check outputs: check_propagate_o = sampled wake; check_lock_o = sampled grant. Both may be high together.
- Push: push[c] = (sampled wake | sampled grant) & propagate_i[c]. One response with several mask bits set is written to every selected channel in the same cycle. A mask bit with no valid sample is ignored.
- Overflow: channel full & push[c] & ~pop_i[c] drops the push on channel c only. Other channels still accept. overflow_o[c] sets next cycle.
- Full channel with push and pop in the same cycle: legal; level unchanged; no error.
- Underflow: pop_i[c] on an empty channel is ignored and sets underflow_o[c] next cycle.
  - Exception: FIFO_COMB_OUT=1 with a simultaneous push to that channel. The element falls through, the FIFO stays empty, and no error is raised.
- Sticky errors hold until err_clr_i. If err_clr_i and a new error occur in the same cycle, the error wins (bit stays 1).
- level_o[c] updates one cycle after push/pop; it ranges 0..FIFO_DEPTH.
- rsp_o[c] is valid only while ~empty_o[c]. Its value is don't-care-stable (holds last head) when empty.
- Latency, rsp_i to rsp_o with an empty FIFO:
  - COMB_IN=0, FIFO_COMB_OUT=1: 1 cycle.
  - Each of COMB_IN=1 or FIFO_COMB_OUT=0 changes this by -1 / +1 cycle respectively.
- FIFOs are circular with wrap-around pointers. Entries are popped strictly in order per channel.
- Elaboration-time fatal checks: N_CHANNELS >= 1 and FIFO_DEPTH >= 1.

Optional Feature:
Macro FRACTAL_SYNC_TX_MC_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o (N_CHANNELS*8). Each channel has an 8-bit saturating count of dropped pushes (stops at 255).
  - Cleared by reset and by err_clr_i. On a simultaneous drop and clear, the count becomes 1.
- Undefined: no port, no counters; all other behaviour is identical.

Test Plan:
- Reset/basic (N_CHANNELS=2, DEPTH=2, COMB_IN=0, COMB_OUT=1): rsp_i wake=1 for 1 cycle; propagate_i=2'b01 on the next cycle -> check_propagate_o=1 for that cycle; empty_o=2'b10, level ch0=1; rsp_o ch0.wake=1.
- Broadcast: grant=1, propagate_i=2'b11 -> both channels level=1 with identical rsp_o; popping ch1 only -> empty_o=2'b10.
- Overflow isolation: fill ch0 to 2 with no pops, then push to 2'b11 -> ch1 level=1, ch0 level=2, overflow_o=2'b01 sticky; err_clr_i=1 -> overflow_o=0 next cycle.
- Full push+pop: ch0 at level 2, push and pop_i[0] in the same cycle -> level stays 2, no overflow, FIFO order preserved.
- Underflow/fall-through: pop empty ch1 -> underflow_o[1]=1. With COMB_OUT=1, push and pop ch0 in the same cycle while empty -> rsp_o shows the pushed element, ch0 stays empty, no error.
- Reset mid-operation: both channels at level 2, assert rst_ni=0 -> empty_o=2'b11, levels 0, errors 0. With the macro, drop_cnt reaches 255 after 300 drops, then resets to 0.
